mem_arbiter: RTL and testbench

- Shares one unified, variable-latency memory port between instruction fetch (IF) and the memory stage's data port (DM).
- Sequences each access through a request/grant/response handshake.
- Generates per-requester stall signals for the hazard unit.
- Drops fetch responses invalidated by a taken branch or jump flush.

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one variable-latency memory port between instruction fetch and data access.
// Each access runs IDLE -> REQ -> WAIT; a flushed fetch is aborted or has its response dropped.
module mem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [DATA_WIDTH-1:0] if_addr_i,
  input  logic                  if_flush_i,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_valid_o,
  output logic                  if_stall_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [DATA_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  input  logic [3:0]            dm_be_i,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  dm_valid_o,
  output logic                  dm_stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_be_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;
  typedef enum logic {OWN_DM = 1'b0, OWN_IF = 1'b1} owner_t;

  // Handshake: mem_req_o is held from REQ entry until the cycle mem_gnt_i is seen high;
  // exactly one mem_rvalid_i follows each grant, and it completes the access in WAIT.
  state_t                state;
  owner_t                owner;
  logic [CW-1:0]         starve_cnt;
  logic                  drop;
  logic                  req_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            be_q;
  logic                  if_wins;
  logic                  resp_if;
  logic                  resp_dm;

  always_comb begin
    if_wins = if_req_i & (~dm_req_i | (starve_cnt == CW'(STARVE_LIMIT)));
    // A flush coinciding with the response also kills that fetch.
    resp_if = (state == WAIT) & mem_rvalid_i & (owner == OWN_IF) & ~drop & ~if_flush_i;
    resp_dm = (state == WAIT) & mem_rvalid_i & (owner == OWN_DM);
  end

  assign if_valid_o  = resp_if;
  assign dm_valid_o  = resp_dm;
  assign if_rdata_o  = resp_if ? mem_rdata_i : '0;
  assign dm_rdata_o  = resp_dm ? mem_rdata_i : '0;
  assign if_stall_o  = if_req_i & ~resp_if;
  assign dm_stall_o  = dm_req_i & ~resp_dm;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_DM;
      starve_cnt <= '0;
      drop       <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req_i | dm_req_i) begin
            state <= REQ;
            req_q <= 1'b1;
            if (if_wins) begin
              owner      <= OWN_IF;
              we_q       <= 1'b0;
              addr_q     <= if_addr_i;
              wdata_q    <= '0;
              be_q       <= 4'hF;
              starve_cnt <= '0;
            end else begin
              owner   <= OWN_DM;
              we_q    <= dm_we_i;
              addr_q  <= dm_addr_i;
              wdata_q <= dm_wdata_i;
              be_q    <= dm_be_i;
              if (if_req_i && starve_cnt != CW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + CW'(1);
            end
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            // A grant always stands; a simultaneous flush only marks the response for dropping.
            state <= WAIT;
            req_q <= 1'b0;
            drop  <= (owner == OWN_IF) & if_flush_i;
          end else if (owner == OWN_IF && if_flush_i) begin
            state <= IDLE;
            req_q <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            state <= IDLE;
            drop  <= 1'b0;
          end else if (owner == OWN_IF && if_flush_i) begin
            drop <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: reactive memory model, table of single accesses, and hand-written
// sequences for contention, starvation, flush and mid-transaction reset.
module tb_mem_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         if_req = 1'b0;
  logic [W-1:0] if_addr = '0;
  logic         if_flush = 1'b0;
  logic [W-1:0] if_rdata_o;
  logic         if_valid_o;
  logic         if_stall_o;
  logic         dm_req = 1'b0;
  logic         dm_we = 1'b0;
  logic [W-1:0] dm_addr = '0;
  logic [W-1:0] dm_wdata = '0;
  logic [3:0]   dm_be = 4'h0;
  logic [W-1:0] dm_rdata_o;
  logic         dm_valid_o;
  logic         dm_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [W-1:0] mem_addr_o;
  logic [W-1:0] mem_wdata_o;
  logic [3:0]   mem_be_o;
  logic         mem_gnt = 1'b0;
  logic         mem_rvalid = 1'b0;
  logic [W-1:0] mem_rdata = '0;

  mem_arbiter #(.DATA_WIDTH(W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o), .if_stall_o(if_stall_o),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_be_i(dm_be), .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o), .dm_stall_o(dm_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // memory model: grants after gnt_delay cycles of request, responds rv_delay cycles later
  int           gnt_delay = 0;
  int           rv_delay = 0;
  bit           keep_on_rst = 1'b0;
  int           g_cnt = 0;
  int           rv_cnt = 0;
  bit           rv_pending = 1'b0;
  logic [W-1:0] rv_data = '0;
  int           grant_cnt = 0;
  int           resp_cnt = 0;

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    case (a)
      32'h0000_0010: mem_word = 32'h0050_0093;
      32'h0001_0000: mem_word = 32'hDEAD_BEEF;
      default:       mem_word = a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  always begin
    @(posedge clk);
    #1;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (rst && !keep_on_rst) begin
      rv_pending = 1'b0;
      g_cnt = 0;
    end else if (rv_pending) begin
      if (rv_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = rv_data;
        rv_pending = 1'b0;
        resp_cnt++;
      end else begin
        rv_cnt--;
      end
    end else if (mem_req_o) begin
      if (g_cnt == gnt_delay) begin
        mem_gnt = 1'b1;
        rv_pending = 1'b1;
        rv_cnt = rv_delay;
        rv_data = mem_we_o ? '0 : mem_word(mem_addr_o);
        g_cnt = 0;
        grant_cnt++;
      end else begin
        g_cnt++;
      end
    end else begin
      g_cnt = 0;
    end
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [W-1:0] if_q[$];
  logic [W-1:0] dm_q[$];
  logic [W-1:0] ord_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit           is_dm;
    bit           we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [3:0]   be;
    int           gd;
    int           rd;
    logic [W-1:0] exp_data;
    int           exp_lat;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs[NV];

  initial begin
    int cyc;
    int n;
    int seen;
    int base_g;
    int base_r;
    bit done;
    bit dm_drop;
    logic [W-1:0] got;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 0, 0, 32'h0050_0093, 2};
    vecs[1] = '{1'b1, 1'b0, 32'h0001_0000, 32'h0,         4'hF, 0, 0, 32'hDEAD_BEEF, 2};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3, 1, 0, 32'h0,         3};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,         4'hF, 2, 1, 32'hA5A5_A5E1, 5};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,         4'hF, 0, 2, 32'hA5A5_A6A5, 4};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, 4'hC, 3, 3, 32'h0,         8};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_valids", {30'd0, if_valid_o, dm_valid_o}, 32'd0);
    chk("rst_state", 32'(dut.state), 32'd0);
    chk("rst_starve", 32'(dut.starve_cnt), 32'd0);
    tick();
    rst = 1'b0;

    // table of single accesses
    for (int i = 0; i < NV; i++) begin
      gnt_delay = vecs[i].gd;
      rv_delay = vecs[i].rd;
      tick();
      if (vecs[i].is_dm) begin
        dm_req = 1'b1; dm_we = vecs[i].we; dm_addr = vecs[i].addr;
        dm_wdata = vecs[i].wdata; dm_be = vecs[i].be;
        dm_q.push_back(vecs[i].exp_data);
      end else begin
        if_req = 1'b1; if_addr = vecs[i].addr;
        if_q.push_back(vecs[i].exp_data);
      end
      done = 1'b0;
      cyc = 0;
      while (!done && cyc < 64) begin
        @(negedge clk);
        if (cyc <= 1)
          chk($sformatf("v%0d_stall_c%0d", i, cyc), 32'(vecs[i].is_dm ? dm_stall_o : if_stall_o), 32'd1);
        if (cyc == 1) begin
          chk($sformatf("v%0d_mem_req", i), 32'(mem_req_o), 32'd1);
          chk($sformatf("v%0d_mem_we", i), 32'(mem_we_o), 32'(vecs[i].we));
          chk($sformatf("v%0d_mem_addr", i), mem_addr_o, vecs[i].addr);
          chk($sformatf("v%0d_mem_wdata", i), mem_wdata_o, vecs[i].is_dm ? vecs[i].wdata : '0);
          chk($sformatf("v%0d_mem_be", i), 32'(mem_be_o), 32'(vecs[i].be));
        end
        if (vecs[i].is_dm ? dm_valid_o : if_valid_o) begin
          done = 1'b1;
          got = vecs[i].is_dm ? dm_rdata_o : if_rdata_o;
          chk($sformatf("v%0d_latency", i), cyc, vecs[i].exp_lat);
          chk($sformatf("v%0d_rdata", i), got, vecs[i].is_dm ? dm_q.pop_front() : if_q.pop_front());
          chk($sformatf("v%0d_other_valid", i), 32'(vecs[i].is_dm ? if_valid_o : dm_valid_o), 32'd0);
          chk($sformatf("v%0d_stall_done", i), 32'(vecs[i].is_dm ? dm_stall_o : if_stall_o), 32'd0);
        end
        cyc++;
      end
      if (!done) chk($sformatf("v%0d_timeout", i), 32'd0, 32'd1);
      tick();
      if_req = 1'b0;
      dm_req = 1'b0;
    end

    // simultaneous IF and DM: DM first, IF re-arbitrated at cycle 3
    gnt_delay = 0; rv_delay = 0;
    tick();
    if_req = 1'b1; if_addr = 32'h0000_0010;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0001_0000; dm_be = 4'hF;
    if_q.push_back(32'h0050_0093);
    dm_q.push_back(32'hDEAD_BEEF);
    n = 0; cyc = 0; dm_drop = 1'b0;
    while (n < 2 && cyc < 40) begin
      @(negedge clk);
      if (dm_valid_o) begin
        chk("sim_dm_lat", cyc, 2);
        chk("sim_dm_rdata", dm_rdata_o, dm_q.pop_front());
        n++; dm_drop = 1'b1;
      end
      if (if_valid_o) begin
        chk("sim_if_lat", cyc, 5);
        chk("sim_if_rdata", if_rdata_o, if_q.pop_front());
        n++;
      end
      cyc++;
      tick();
      if (dm_drop) dm_req = 1'b0;
    end
    chk("sim_count", n, 2);
    if_req = 1'b0;

    // starvation: four DM wins then IF forced, then DM again
    tick();
    if_req = 1'b1; if_addr = 32'h0000_0010;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0100; dm_be = 4'hF;
    for (int k = 0; k < 6; k++) ord_q.push_back(k == 4 ? 32'd0 : 32'd1);
    n = 0; cyc = 0;
    while (n < 6 && cyc < 120) begin
      @(negedge clk);
      if (dm_valid_o || if_valid_o) begin
        chk($sformatf("starve_owner%0d", n), 32'(dm_valid_o), ord_q.pop_front());
        chk($sformatf("starve_data%0d", n), dm_valid_o ? dm_rdata_o : if_rdata_o,
            dm_valid_o ? 32'hA5A5_A4A5 : 32'h0050_0093);
        if (n == 3) chk("starve_cnt_sat", 32'(dut.starve_cnt), 32'd4);
        if (n == 4) chk("starve_cnt_clr", 32'(dut.starve_cnt), 32'd0);
        n++;
      end
      cyc++;
      tick();
      if (n >= 5) if_req = 1'b0;
      if (n >= 6) dm_req = 1'b0;
    end
    chk("starve_count", n, 6);

    // flush in REQ: aborted, then a new fetch from 0x80
    gnt_delay = 3; rv_delay = 0;
    base_g = grant_cnt;
    tick();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    tick();
    @(negedge clk);
    chk("fr_state_req", 32'(dut.state), 32'd1);
    tick();
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0; if_addr = 32'h0000_0080;
    if_q.push_back(32'hA5A5_A525);
    @(negedge clk);
    chk("fr_mem_req_drop", 32'(mem_req_o), 32'd0);
    chk("fr_state_idle", 32'(dut.state), 32'd0);
    chk("fr_no_grant", grant_cnt, base_g);
    done = 1'b0; cyc = 0;
    while (!done && cyc < 40) begin
      if (if_valid_o) begin
        done = 1'b1;
        chk("fr_refetch_lat", cyc, 5);
        chk("fr_refetch_rdata", if_rdata_o, if_q.pop_front());
      end
      cyc++;
      if (!done) @(negedge clk);
    end
    if (!done) chk("fr_refetch_timeout", 32'd0, 32'd1);
    chk("fr_grants", grant_cnt, base_g + 1);
    tick();
    if_req = 1'b0;

    // flush in WAIT: response consumed, no valid
    gnt_delay = 0; rv_delay = 3;
    base_g = grant_cnt; base_r = resp_cnt;
    tick();
    if_req = 1'b1; if_addr = 32'h0000_0060;
    tick();
    tick();
    if_flush = 1'b1;
    @(negedge clk);
    chk("fw_state_wait", 32'(dut.state), 32'd2);
    tick();
    if_flush = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("fw_drop_set", 32'(dut.drop), 32'd1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (if_valid_o || dm_valid_o) seen++;
    end
    chk("fw_no_valid", seen, 0);
    chk("fw_resp_consumed", resp_cnt, base_r + 1);
    chk("fw_grants", grant_cnt, base_g + 1);
    chk("fw_state_idle", 32'(dut.state), 32'd0);
    chk("fw_drop_clr", 32'(dut.drop), 32'd0);

    // reset while in WAIT; the late response must not surface
    keep_on_rst = 1'b1;
    base_r = resp_cnt;
    tick();
    if_req = 1'b1; if_addr = 32'h0000_0020;
    tick();
    tick();
    rst = 1'b1; if_req = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rw_ctrl_zero", {25'd0, mem_req_o, mem_we_o, if_valid_o, dm_valid_o, if_stall_o, dm_stall_o, 1'b0}, 32'd0);
    chk("rw_be_zero", 32'(mem_be_o), 32'd0);
    chk("rw_addr_zero", mem_addr_o, 32'd0);
    chk("rw_wdata_zero", mem_wdata_o, 32'd0);
    chk("rw_state_idle", 32'(dut.state), 32'd0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (if_valid_o || dm_valid_o) seen++;
    end
    chk("rw_no_late_valid", seen, 0);
    chk("rw_late_resp_seen", resp_cnt, base_r + 1);
    keep_on_rst = 1'b0;

    chk("if_q_empty", if_q.size(), 0);
    chk("dm_q_empty", dm_q.size(), 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
